fp_multiplier: RTL



---
 rtl/fp_multiplier_if.sv | 27 ++
 rtl/fp_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_if.sv
// fp_multiplier_if: operand/result bundle for the sequential FP multiplier.
//   A, B      : IEEE-754 single operands, sampled on an accepted start
//   start     : operation request
//   out       : IEEE-754 product, held between done pulses
//   busy      : operation in flight
//   done      : one-cycle pulse when out/exception update
//   exception : overflow/underflow or Inf/NaN operand
// master drives the request side (sequencer, bench); slave is the multiplier.
interface fp_multiplier_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        exception;

    modport master (
        output A, B, start,
        input  out, busy, done, exception
    );

    modport slave (
        input  A, B, start,
        output out, busy, done, exception
    );
endinterface

// File: rtl/fp_multiplier.sv
// fp_multiplier: sequential IEEE-754 single-precision multiplier.
// A radix-2 shift-add mantissa multiplier retires one multiplier bit per clock;
// every operation takes exactly 25 edges from start acceptance to the result.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : fp_multiplier_if.slave (A, B, start in; out, busy, done, exception out)
// Build option:
//   FPMUL_ROUND_EN : round-to-nearest-even; otherwise the fraction is truncated.
module fp_multiplier (
    input  logic            clk,
    input  logic            reset,
    fp_multiplier_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMul, StNorm} state_e;

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [23:0] ma_q, ma_d;
    logic [23:0] mb_q, mb_d;
    logic [47:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        exc_q, exc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Result formatting from the latched fields and the finished product.
    logic signed [9:0] exp_s;
    logic [22:0]       frac;
    logic [31:0]       res;
    logic              res_exc;
`ifdef FPMUL_ROUND_EN
    logic              guard;
    logic              sticky;
    logic [23:0]       frac_rnd;
`endif

    always_comb begin
        exp_s = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127
                + $signed({9'd0, p_q[47]});
        frac  = p_q[47] ? p_q[46:24] : p_q[45:23];
`ifdef FPMUL_ROUND_EN
        guard    = p_q[47] ? p_q[23] : p_q[22];
        sticky   = p_q[47] ? |p_q[22:0] : |p_q[21:0];
        frac_rnd = {1'b0, frac};
        if (guard && (sticky || frac[0])) begin
            frac_rnd = {1'b0, frac} + 24'd1;
        end
        // Carry out of the fraction: mantissa becomes 2.0, so renormalize.
        frac = frac_rnd[22:0];
        if (frac_rnd[23]) begin
            exp_s = exp_s + 10'sd1;
        end
`endif
        res     = {sign_q, exp_s[7:0], frac};
        res_exc = 1'b0;
        if (ea_q == 8'hFF || eb_q == 8'hFF) begin
            res     = {sign_q, 8'hFF, 23'd0};
            res_exc = 1'b1;
        end else if (ea_q == 8'h00 || eb_q == 8'h00) begin
            // Zero and denormal operands are flushed to a signed zero.
            res     = {sign_q, 31'd0};
            res_exc = 1'b0;
        end else if (exp_s >= 10'sd255) begin
            res     = {sign_q, 8'hFF, 23'd0};
            res_exc = 1'b1;
        end else if (exp_s <= 10'sd0) begin
            res     = {sign_q, 31'd0};
            res_exc = 1'b1;
        end
    end

    // Shift-add step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    logic [24:0] acc;
    assign acc = {1'b0, p_q[47:24]} + (mb_q[0] ? {1'b0, ma_q} : 25'd0);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        exc_d   = exc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sign_d  = bus.A[31] ^ bus.B[31];
                    ea_d    = bus.A[30:23];
                    eb_d    = bus.B[30:23];
                    ma_d    = {1'b1, bus.A[22:0]};
                    mb_d    = {1'b1, bus.B[22:0]};
                    p_d     = 48'd0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = StMul;
                end
            end
            StMul: begin
                p_d   = {acc, p_q[23:1]};
                mb_d  = {1'b0, mb_q[23:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                out_d   = res;
                exc_d   = res_exc;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            ma_q    <= 24'd0;
            mb_q    <= 24'd0;
            p_q     <= 48'd0;
            cnt_q   <= 5'd0;
            out_q   <= 32'd0;
            exc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            exc_q   <= exc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.exception = exc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
